// File: rtl/aes_key_schedule_engine_if.sv
// aes_key_schedule_engine_if: start/key command and round-key read bus of the AES key schedule engine.
interface aes_key_schedule_engine_if #(
    parameter int MAX_KEY_BITS = 256
);
    logic                    start;
    logic [1:0]              key_len;
    logic [MAX_KEY_BITS-1:0] key;
    logic                    busy;
    logic                    done;
    logic                    key_ready;
    logic                    err;
    logic                    rd_en;
    logic [3:0]              rd_round;
    logic                    rd_valid;
    logic [127:0]            rd_data;
    logic [3:0]              nr;

    modport master (
        output start, key_len, key, rd_en, rd_round,
        input  busy, done, key_ready, err, rd_valid, rd_data, nr
    );
    modport slave (
        input  start, key_len, key, rd_en, rd_round,
        output busy, done, key_ready, err, rd_valid, rd_data, nr
    );
endinterface

// File: rtl/aes_key_schedule_engine.sv
// aes_key_schedule_engine: iterative AES-128/192/256 key expansion, one word per step, registered round-key read port.
// Optional KS_ZEROIZE_EN adds a zeroize input that wipes the whole word array.
module aes_key_schedule_engine #(
    parameter int MAX_KEY_BITS = 256,
    parameter bit SBOX_PIPE    = 1'b0
) (
    input logic clk,
    input logic rst,
`ifdef KS_ZEROIZE_EN
    input logic zeroize,
`endif
    aes_key_schedule_engine_if.slave bus
);
    localparam int NK_MAX = MAX_KEY_BITS / 32;
    localparam int NW_MAX = 4 * (NK_MAX + 7);
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {IDLE, GEN, ZERO} state_t;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    state_t      state, state_n;
    logic [31:0] w [NW_MAX];
    logic [5:0]  idx;
    logic [2:0]  pos;
    logic [3:0]  nk, nk_req, nr_q;
    logic [7:0]  rcon;
    logic        half, legal, load, step, zero_we, last, zap, rd_ok;
    logic [31:0] temp, sub_in, sub_c, sub_q, sub_out, nxt;

`ifdef KS_ZEROIZE_EN
    assign zap = zeroize && state != ZERO;
`else
    assign zap = 1'b0;
`endif

    assign nk_req = (bus.key_len == 2'd0) ? 4'd4 : (bus.key_len == 2'd1) ? 4'd6 : 4'd8;
    assign legal  = bus.key_len != 2'd3 && 32 * int'(nk_req) <= MAX_KEY_BITS;
    assign last   = idx == {nr_q, 2'b11};
    assign bus.nr = nr_q;

    // pos tracks idx % Nk so no divider is needed
    assign temp    = w[idx - 6'd1];
    assign sub_in  = (pos == 3'd0) ? {temp[23:0], temp[31:24]} : temp;
    assign sub_c   = {sbox(sub_in[31:24]), sbox(sub_in[23:16]), sbox(sub_in[15:8]), sbox(sub_in[7:0])};
    assign sub_out = SBOX_PIPE ? sub_q : sub_c;
    assign nxt     = w[idx - {2'b00, nk}] ^ ((pos == 3'd0) ? sub_out ^ {rcon, 24'h0} :
                     (nk == 4'd8 && pos == 3'd4) ? sub_out : temp);

    assign rd_ok = bus.rd_en && state != ZERO && bus.rd_round <= nr_q && {bus.rd_round, 2'b11} < idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (zap) state_n = ZERO;
        else if (load) state_n = GEN;
        else if (step && last) state_n = IDLE;
        else if (zero_we && idx == 6'(NW_MAX - 1)) state_n = IDLE;
    end

    always_comb begin
        bus.busy = state != IDLE;
        load     = state == IDLE && bus.start && legal && !zap;
        step     = state == GEN && (!SBOX_PIPE || half) && !zap;
        zero_we  = state == ZERO;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx           <= 6'd0;
            pos           <= 3'd0;
            nk            <= 4'd4;
            nr_q          <= 4'd0;
            rcon          <= 8'h01;
            half          <= 1'b0;
            bus.done      <= 1'b0;
            bus.err       <= 1'b0;
            bus.key_ready <= 1'b0;
            bus.rd_valid  <= 1'b0;
            bus.rd_data   <= '0;
        end else begin
            bus.done     <= step && last;
            bus.err      <= state == IDLE && bus.start && !legal && !zap;
            half         <= state == GEN && !half;
            bus.rd_valid <= rd_ok;
            bus.rd_data  <= rd_ok ? {w[{bus.rd_round, 2'b00}], w[{bus.rd_round, 2'b01}],
                                     w[{bus.rd_round, 2'b10}], w[{bus.rd_round, 2'b11}]} : '0;
            if (zap) begin
                idx           <= 6'd0;
                bus.key_ready <= 1'b0;
            end else if (load) begin
                nk            <= nk_req;
                nr_q          <= nk_req + 4'd6;
                idx           <= {2'b00, nk_req};
                pos           <= 3'd0;
                rcon          <= 8'h01;
                half          <= 1'b0;
                bus.key_ready <= 1'b0;
            end else if (step) begin
                idx  <= idx + 6'd1;
                pos  <= (pos == 3'(nk - 4'd1)) ? 3'd0 : pos + 3'd1;
                rcon <= (pos == 3'd0) ? xtime(rcon) : rcon;
                if (last) bus.key_ready <= 1'b1;
            end else if (zero_we) begin
                idx <= (idx == 6'(NW_MAX - 1)) ? 6'd0 : idx + 6'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        sub_q <= sub_c;
        if (load)
            for (int i = 0; i < NK_MAX; i++)
                if (i < int'(nk_req)) w[i] <= bus.key[MAX_KEY_BITS-1-32*i -: 32];
        if (step) w[idx] <= nxt;
        if (zero_we) w[idx] <= 32'h0;
    end
endmodule

// File: tb/tb_aes_key_schedule_engine.sv
// tb_aes_key_schedule_engine: directed FIPS-197 key-expansion vectors, early reads, errors and reset.
module tb_aes_key_schedule_engine;
    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] R128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] R128_1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] R192_12 = 128'he98ba06f448c773c8ecc720401002202;
    localparam logic [127:0] R256_14 = 128'hfe4890d1e6188d0b046df344706c631e;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int fails = 0;

    aes_key_schedule_engine_if #(.MAX_KEY_BITS(256)) bus();
`ifdef KS_ZEROIZE_EN
    logic zeroize = 1'b0;
`endif

    aes_key_schedule_engine #(.MAX_KEY_BITS(256), .SBOX_PIPE(1'b0)) dut (
        .clk(clk),
        .rst(rst),
`ifdef KS_ZEROIZE_EN
        .zeroize(zeroize),
`endif
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run_key(input string tag, input logic [1:0] len, input logic [255:0] k, input int exp_cycles);
        int n = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.key_len = len; bus.key = k;
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, " busy"}, bus.busy, 1);
        check({tag, " key_ready drop"}, bus.key_ready, 0);
        while (!bus.done && n < 200) begin
            n++;
            @(negedge clk);
        end
        check({tag, " latency"}, n, exp_cycles);
        check({tag, " busy end"}, bus.busy, 0);
        check({tag, " key_ready"}, bus.key_ready, 1);
    endtask

    task automatic read_round(input logic [3:0] r);
        bus.rd_en = 1'b1; bus.rd_round = r;
        @(negedge clk);
        bus.rd_en = 1'b0;
    endtask

    initial begin
        int e;
        int n;
        bus.start = 1'b0; bus.key_len = 2'd0; bus.key = '0;
        bus.rd_en = 1'b0; bus.rd_round = 4'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset busy", bus.busy, 0);
        check("reset done", bus.done, 0);
        check("reset key_ready", bus.key_ready, 0);
        check("reset err", bus.err, 0);
        check("reset rd_valid", bus.rd_valid, 0);
        check("reset rd_data", bus.rd_data, 0);
        check("reset nr", bus.nr, 0);

        run_key("aes128", 2'd0, K128, 40);
        check("aes128 nr", bus.nr, 10);
        read_round(4'd10);
        check("aes128 r10 valid", bus.rd_valid, 1);
        check("aes128 r10 data", bus.rd_data, R128_10);
        read_round(4'd0);
        check("aes128 r0 data", bus.rd_data, K128[255:128]);
        read_round(4'd11);
        check("aes128 r11 invalid", bus.rd_valid, 0);
        check("aes128 r11 data", bus.rd_data, 0);

        run_key("aes192", 2'd1, K192, 46);
        check("aes192 nr", bus.nr, 12);
        read_round(4'd12);
        check("aes192 r12 valid", bus.rd_valid, 1);
        check("aes192 r12 data", bus.rd_data, R192_12);

        run_key("aes256", 2'd2, K256, 52);
        check("aes256 nr", bus.nr, 14);
        read_round(4'd14);
        check("aes256 r14 valid", bus.rd_valid, 1);
        check("aes256 r14 data", bus.rd_data, R256_14);
        read_round(4'd15);
        check("aes256 r15 invalid", bus.rd_valid, 0);
        @(negedge clk);
        check("rd_en low", bus.rd_valid, 0);

`ifdef KS_ZEROIZE_EN
        zeroize = 1'b1;
        @(negedge clk);
        zeroize = 1'b0;
        check("zero key_ready", bus.key_ready, 0);
        n = 0;
        while (bus.busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("zero busy cycles", n, 60);
        check("zero no done", bus.done, 0);
        read_round(4'd0);
        check("zero r0 invalid", bus.rd_valid, 0);
`endif

        // early reads during generation, then an ignored start mid-run
        bus.start = 1'b1; bus.key_len = 2'd0; bus.key = K128;
        @(negedge clk);
        bus.start = 1'b0; bus.rd_en = 1'b1; bus.rd_round = 4'd0;
        @(negedge clk);
        check("early r0 valid", bus.rd_valid, 1);
        check("early r0 data", bus.rd_data, K128[255:128]);
        bus.rd_round = 4'd1;
        e = 1;
        do begin
            @(negedge clk);
            e++;
        end while (!bus.rd_valid && e < 20);
        check("early r1 rise edge", e, 5);
        check("early r1 data", bus.rd_data, R128_1);
        bus.rd_en = 1'b0;
        bus.start = 1'b1; bus.key_len = 2'd2; bus.key = K256;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        check("overlap no err", bus.err, 0);
        check("overlap busy", bus.busy, 1);
        n = 0;
        while (!bus.done && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("overlap done cycle", n, 33);
        check("overlap nr", bus.nr, 10);
        read_round(4'd10);
        check("overlap r10 data", bus.rd_data, R128_10);

        bus.start = 1'b1; bus.key_len = 2'd3;
        @(negedge clk);
        bus.start = 1'b0;
        check("illegal err", bus.err, 1);
        check("illegal busy", bus.busy, 0);
        @(negedge clk);
        check("illegal err pulse", bus.err, 0);

        // reset once idx reaches 20 (16 generation edges after load)
        bus.start = 1'b1; bus.key_len = 2'd0; bus.key = K128;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (16) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midreset busy", bus.busy, 0);
        check("midreset key_ready", bus.key_ready, 0);
        check("midreset nr", bus.nr, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int r = 0; r <= 10; r++) begin
            read_round(4'(r));
            check($sformatf("midreset r%0d invalid", r), bus.rd_valid, 0);
        end

        run_key("restart", 2'd0, K128, 40);
        read_round(4'd10);
        check("restart r10 valid", bus.rd_valid, 1);
        check("restart r10 data", bus.rd_data, R128_10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
